// File: rtl/mul_issue_scheduler.sv
// mul_issue_scheduler: round-robin arbiter feeding one shared sequential multiplier, one op in flight,
// with popcount operand swap, zero-operand fast path and per-port flush of the owned op.
module mul_issue_scheduler #(
  parameter int NUM_REQ = 2,
  parameter bit SWAP_EN = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  input  logic [NUM_REQ*32-1:0] req_op_a_i,
  input  logic [NUM_REQ*32-1:0] req_op_b_i,
  input  logic [NUM_REQ*5-1:0] req_rd_idx_i,
  input  logic [NUM_REQ-1:0]   flush_i,
  output logic [NUM_REQ-1:0]   resp_valid_o,
  output logic [31:0]          resp_result_o,
  output logic [4:0]           resp_rd_idx_o,
  output logic                 mul_start_o,
  output logic [31:0]          mul_op_a_o,
  output logic [31:0]          mul_op_b_o,
  output logic [4:0]           mul_rd_idx_o,
  input  logic                 mul_busy_i,
  input  logic                 mul_done_i,
  input  logic [31:0]          mul_result_i,
  input  logic [4:0]           mul_rd_idx_i,
  output logic                 busy_o
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  state_e state_q, state_d;
  logic [PW-1:0] rr_q, rr_d, owner_q, owner_d, gnt;
  logic kill_q, kill_d, gnt_vld, swap;
  logic [31:0] op_a_q, op_a_d, op_b_q, op_b_d, res_q, res_d, a_sel, b_sel;
  logic [4:0] rd_q, rd_d, rd_sel;
  logic [NUM_REQ-1:0] elig;
  logic unused_tag;
  assign unused_tag = ^mul_rd_idx_i;
  assign elig = req_valid_i & ~flush_i;
  // Descending scan so the eligible port closest to rr_q is the last writer and wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (elig[(int'(rr_q) + i) % NUM_REQ]) begin
        gnt_vld = 1'b1;
        gnt = PW'((int'(rr_q) + i) % NUM_REQ);
      end
    end
  end
  assign a_sel  = req_op_a_i[32*int'(gnt) +: 32];
  assign b_sel  = req_op_b_i[32*int'(gnt) +: 32];
  assign rd_sel = req_rd_idx_i[5*int'(gnt) +: 5];
  assign swap   = SWAP_EN && ($countones(b_sel) < $countones(a_sel));
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    owner_d = owner_q;
    kill_d = kill_q;
    op_a_d = op_a_q;
    op_b_d = op_b_q;
    res_d = res_q;
    rd_d = rd_q;
    req_ready_o = '0;
    resp_valid_o = '0;
    mul_start_o = 1'b0;
    case (state_q)
      IDLE: if (gnt_vld) begin
        req_ready_o[gnt] = rst_n_i;
        owner_d = gnt;
        rr_d = PW'((int'(gnt) + 1) % NUM_REQ);
        rd_d = rd_sel;
        op_a_d = swap ? b_sel : a_sel;
        op_b_d = swap ? a_sel : b_sel;
        kill_d = 1'b0;
        res_d = '0;
        state_d = (a_sel == '0 || b_sel == '0) ? RESP : ISSUE;
      end
      ISSUE: begin
        kill_d = kill_q | flush_i[owner_q];
        mul_start_o = !mul_busy_i;
        state_d = mul_busy_i ? ISSUE : WAIT;
      end
      WAIT: begin
        kill_d = kill_q | flush_i[owner_q];
        res_d = mul_done_i ? mul_result_i : res_q;
        state_d = mul_done_i ? RESP : WAIT;
      end
      default: begin
        resp_valid_o[owner_q] = !(kill_q || flush_i[owner_q]);
        kill_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      rr_q <= '0;
      owner_q <= '0;
      kill_q <= 1'b0;
      op_a_q <= '0;
      op_b_q <= '0;
      res_q <= '0;
      rd_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      owner_q <= owner_d;
      kill_q <= kill_d;
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
      res_q <= res_d;
      rd_q <= rd_d;
    end
  end
  assign mul_op_a_o    = op_a_q;
  assign mul_op_b_o    = op_b_q;
  assign mul_rd_idx_o  = rd_q;
  assign resp_result_o = res_q;
  assign resp_rd_idx_o = rd_q;
  assign busy_o        = state_q != IDLE;
endmodule
